// File: rtl/mem_arbiter.sv
// Arbiter for the shared instruction/data memory: IF vs LS grant,
// store lane/mask generation, load extension and registered responses.
module mem_arbiter #(
  parameter int CNT_W       = 16,
  parameter bit LS_PRIORITY = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_if_req,
  input  logic [31:0]      i_if_addr,
  output logic             o_if_gnt,
  output logic             o_if_rvalid,
  output logic [31:0]      o_if_rdata,
  output logic             o_if_err,
  input  logic             i_ls_req,
  input  logic             i_ls_we,
  input  logic [1:0]       i_ls_size,
  input  logic             i_ls_unsigned,
  input  logic [31:0]      i_ls_addr,
  input  logic [31:0]      i_ls_wdata,
  output logic             o_ls_gnt,
  output logic             o_ls_rvalid,
  output logic [31:0]      o_ls_rdata,
  output logic             o_ls_err,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic [3:0]       o_mem_bmask,
  output logic             o_mem_wren,
  input  logic [31:0]      i_mem_rdata,
  output logic [CNT_W-1:0] o_conflict_cnt
);

  logic [1:0]       off;
  logic             if_err;
  logic             ls_err;
  logic             last_ls;
  logic [3:0]       st_bmask;
  logic [31:0]      st_wdata;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;
  logic             if_rvalid_q;
  logic             if_err_q;
  logic [31:0]      if_rdata_q;
  logic             ls_rvalid_q;
  logic             ls_err_q;
  logic [31:0]      ls_rdata_q;
  logic [CNT_W-1:0] cnt;

  assign off    = i_ls_addr[1:0];
  assign if_err = |i_if_addr[1:0];

  always_comb begin
    ls_err = 1'b0;
    case (i_ls_size)
      2'b00:   ls_err = 1'b0;
      2'b01:   ls_err = off[0];
      2'b10:   ls_err = |off;
      default: ls_err = 1'b1;
    endcase
  end

  // last_ls starts at 1 so IF wins the first conflict after reset
  always_comb begin
    o_if_gnt = 1'b0;
    o_ls_gnt = 1'b0;
    if (!i_reset) begin
      if (i_if_req && i_ls_req) begin
        if (LS_PRIORITY || !last_ls) o_ls_gnt = 1'b1;
        else                         o_if_gnt = 1'b1;
      end else begin
        o_if_gnt = i_if_req;
        o_ls_gnt = i_ls_req;
      end
    end
  end

  always_comb begin
    st_bmask = 4'hf;
    st_wdata = i_ls_wdata;
    case (i_ls_size)
      2'b00: begin
        st_bmask = 4'b0001 << off;
        st_wdata = {4{i_ls_wdata[7:0]}};
      end
      2'b01: begin
        st_bmask = 4'b0011 << off;
        st_wdata = {2{i_ls_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = '0;
    o_mem_wren  = 1'b0;
    if (o_if_gnt) begin
      o_mem_addr = i_if_addr;
    end else if (o_ls_gnt) begin
      o_mem_addr = i_ls_addr;
      if (i_ls_we && !ls_err) begin
        o_mem_wdata = st_wdata;
        o_mem_bmask = st_bmask;
        o_mem_wren  = 1'b1;
      end
    end
  end

  assign ld_byte = i_mem_rdata[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    ld_data = i_mem_rdata;
    case (i_ls_size)
      2'b00:   ld_data = {{24{~i_ls_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~i_ls_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
      last_ls     <= 1'b1;
      cnt         <= '0;
    end else begin
      if_rvalid_q <= o_if_gnt;
      if_err_q    <= o_if_gnt & if_err;
      if_rdata_q  <= (o_if_gnt && !if_err) ? i_mem_rdata : '0;
      ls_rvalid_q <= o_ls_gnt;
      ls_err_q    <= o_ls_gnt & ls_err;
      ls_rdata_q  <= (o_ls_gnt && !ls_err && !i_ls_we) ? ld_data : '0;
      if (o_if_gnt)      last_ls <= 1'b0;
      else if (o_ls_gnt) last_ls <= 1'b1;
      if (i_if_req && i_ls_req && cnt != {CNT_W{1'b1}})
        cnt <= cnt + CNT_W'(1);
    end
  end

  // a response pending when reset rises is suppressed immediately
  assign o_if_rvalid    = if_rvalid_q & ~i_reset;
  assign o_if_err       = if_err_q & ~i_reset;
  assign o_if_rdata     = i_reset ? '0 : if_rdata_q;
  assign o_ls_rvalid    = ls_rvalid_q & ~i_reset;
  assign o_ls_err       = ls_err_q & ~i_reset;
  assign o_ls_rdata     = i_reset ? '0 : ls_rdata_q;
  assign o_conflict_cnt = cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default instance plus a
// CNT_W=2 / LS_PRIORITY=1 instance sharing the same stimulus.
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        i_ls_req;
  logic        i_ls_we;
  logic [1:0]  i_ls_size;
  logic        i_ls_unsigned;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic [31:0] i_mem_rdata;

  logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_wren;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_bmask;
  logic [15:0] conflict_cnt;

  logic        s_if_gnt, s_if_rvalid, s_if_err, s_ls_gnt, s_ls_rvalid;
  logic        s_ls_err, s_mem_wren;
  logic [31:0] s_if_rdata, s_ls_rdata, s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_bmask;
  logic [1:0]  s_conflict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  mem_arbiter #(.CNT_W(16), .LS_PRIORITY(1'b0)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid),
    .o_if_rdata(if_rdata), .o_if_err(if_err),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we),
    .i_ls_size(i_ls_size), .i_ls_unsigned(i_ls_unsigned),
    .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata),
    .o_ls_gnt(ls_gnt), .o_ls_rvalid(ls_rvalid),
    .o_ls_rdata(ls_rdata), .o_ls_err(ls_err),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_bmask(mem_bmask), .o_mem_wren(mem_wren),
    .i_mem_rdata(i_mem_rdata), .o_conflict_cnt(conflict_cnt)
  );

  mem_arbiter #(.CNT_W(2), .LS_PRIORITY(1'b1)) sat (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(s_if_gnt), .o_if_rvalid(s_if_rvalid),
    .o_if_rdata(s_if_rdata), .o_if_err(s_if_err),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we),
    .i_ls_size(i_ls_size), .i_ls_unsigned(i_ls_unsigned),
    .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata),
    .o_ls_gnt(s_ls_gnt), .o_ls_rvalid(s_ls_rvalid),
    .o_ls_rdata(s_ls_rdata), .o_ls_err(s_ls_err),
    .o_mem_addr(s_mem_addr), .o_mem_wdata(s_mem_wdata),
    .o_mem_bmask(s_mem_bmask), .o_mem_wren(s_mem_wren),
    .i_mem_rdata(i_mem_rdata), .o_conflict_cnt(s_conflict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_if_req = 1'b0;
    i_ls_req = 1'b0;
  endtask

  task automatic ls_op(input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata);
    i_ls_req      = 1'b1;
    i_ls_we       = we;
    i_ls_size     = size;
    i_ls_unsigned = uns;
    i_ls_addr     = addr;
    i_ls_wdata    = wdata;
  endtask

  task automatic do_load(input string tag, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] exp);
    ls_op(1'b0, size, uns, addr, 32'h0);
    #1;
    check({tag, "_gnt"}, {31'b0, ls_gnt}, 32'd1);
    check({tag, "_bmask"}, {28'b0, mem_bmask}, 32'd0);
    check({tag, "_wren"}, {31'b0, mem_wren}, 32'd0);
    tick();
    idle();
    check({tag, "_rvalid"}, {31'b0, ls_rvalid}, 32'd1);
    check({tag, "_rdata"}, ls_rdata, exp);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    i_if_req = 1'b1; i_if_addr = 32'h0;
    ls_op(1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFF);
    i_mem_rdata = 32'h0;
    #1;
    check("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    check("rst_ls_gnt", {31'b0, ls_gnt}, 32'd0);
    check("rst_wren", {31'b0, mem_wren}, 32'd0);
    tick();
    tick();
    check("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    check("rst_ls_rvalid", {31'b0, ls_rvalid}, 32'd0);
    check("rst_cnt", {16'b0, conflict_cnt}, 32'd0);
    idle();
    i_reset = 1'b0;
    tick();

    i_if_req = 1'b1; i_if_addr = 32'h10; i_mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("if_gnt", {31'b0, if_gnt}, 32'd1);
    check("if_mem_addr", mem_addr, 32'h10);
    tick();
    idle();
    check("if_rvalid", {31'b0, if_rvalid}, 32'd1);
    check("if_rdata", if_rdata, 32'hDEAD_BEEF);
    check("if_err", {31'b0, if_err}, 32'd0);
    tick();
    check("if_rvalid_pulse", {31'b0, if_rvalid}, 32'd0);

    do_reset();
    i_if_req = 1'b1; i_if_addr = 32'h20;
    ls_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_if_%0d", k), {31'b0, if_gnt}, {31'b0, k[0] == 1'b0});
      check($sformatf("rr_ls_%0d", k), {31'b0, ls_gnt}, {31'b0, k[0] == 1'b1});
      check($sformatf("pri_ls_%0d", k), {31'b0, s_ls_gnt}, 32'd1);
      tick();
    end
    idle();
    check("rr_cnt", {16'b0, conflict_cnt}, 32'd4);

    ls_op(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5);
    #1;
    check("sb_bmask", {28'b0, mem_bmask}, 32'h8);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb_wren", {31'b0, mem_wren}, 32'd1);
    check("sb_addr", mem_addr, 32'h103);
    tick();
    idle();
    #1;
    check("sb_wren_off", {31'b0, mem_wren}, 32'd0);
    check("sb_rvalid", {31'b0, ls_rvalid}, 32'd1);
    check("sb_rdata", ls_rdata, 32'h0);
    check("sb_err", {31'b0, ls_err}, 32'd0);

    ls_op(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_1234);
    #1;
    check("sh_bmask", {28'b0, mem_bmask}, 32'hC);
    check("sh_wdata", mem_wdata, 32'h1234_1234);
    tick();
    idle();

    i_mem_rdata = 32'h80F0_7F01;
    do_load("lh_s", 2'b01, 1'b0, 32'h202, 32'hFFFF_80F0);
    do_load("lbu", 2'b00, 1'b1, 32'h201, 32'h0000_007F);
    do_load("lb_s0", 2'b00, 1'b0, 32'h200, 32'h0000_0001);
    do_load("lhu", 2'b01, 1'b1, 32'h202, 32'h0000_80F0);
    do_load("lb_s2", 2'b00, 1'b0, 32'h202, 32'hFFFF_FFF0);
    do_load("lw", 2'b10, 1'b1, 32'h200, 32'h80F0_7F01);

    ls_op(1'b1, 2'b10, 1'b0, 32'h202, 32'h1111_2222);
    #1;
    check("sw_mis_gnt", {31'b0, ls_gnt}, 32'd1);
    check("sw_mis_wren", {31'b0, mem_wren}, 32'd0);
    tick();
    idle();
    check("sw_mis_rvalid", {31'b0, ls_rvalid}, 32'd1);
    check("sw_mis_err", {31'b0, ls_err}, 32'd1);
    check("sw_mis_rdata", ls_rdata, 32'h0);

    i_if_req = 1'b1; i_if_addr = 32'h6;
    #1;
    check("if_mis_gnt", {31'b0, if_gnt}, 32'd1);
    tick();
    idle();
    check("if_mis_rvalid", {31'b0, if_rvalid}, 32'd1);
    check("if_mis_err", {31'b0, if_err}, 32'd1);
    check("if_mis_rdata", if_rdata, 32'h0);

    i_if_req = 1'b1; i_if_addr = 32'h10;
    tick();
    idle();
    i_reset = 1'b1;
    #1;
    check("rst_drop_rvalid", {31'b0, if_rvalid}, 32'd0);
    tick();
    check("rst_drop_rvalid2", {31'b0, if_rvalid}, 32'd0);
    i_reset = 1'b0;
    check("rst2_cnt", {16'b0, conflict_cnt}, 32'd0);

    i_if_req = 1'b1; i_if_addr = 32'h30;
    ls_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    #1;
    check("rst2_first_if", {31'b0, if_gnt}, 32'd1);
    for (int k = 0; k < 5; k++) tick();
    idle();
    check("cnt_5", {16'b0, conflict_cnt}, 32'd5);
    check("sat_cnt", {30'b0, s_conflict_cnt}, 32'd3);
    tick();
    check("sat_hold", {30'b0, s_conflict_cnt}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
